// File: rtl/uart_tx_holding_fifo.sv
// Holding FIFO in front of the UART transmitter FSM.
// Buffers bytes from the UCLK-domain write logic. It offers one byte to the
// FSM whenever the FSM is idle. Each pop loads a holding register, so tx_data
// and parity_bit stay stable for the whole frame.
module uart_tx_holding_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          parity_type,
  input  logic                          busy,
  output logic                          data_valid,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          parity_bit,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          overflow_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Flags and handshake are decoded from the pre-edge fill count.
  always_comb begin
    full       = (count == CW'(FIFO_DEPTH));
    empty      = (count == '0);
    data_valid = !empty && !busy;
    wr_ok      = wr_en && !full;
    pop        = data_valid;
    head       = mem[rd_ptr];
    fill_level = count;
  end

  // Storage array; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge UCLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Fill counter: a write and a pop on the same edge cancel out.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Holding register changes only on a pop. Parity uses the mode sampled at that moment.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      tx_data    <= '0;
      parity_bit <= 1'b0;
    end else if (pop) begin
      tx_data    <= head;
      parity_bit <= (^head) ^ parity_type;
    end
  end

  // Sticky overflow flag. A dropped write beats a clear on the same edge.
  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_holding_fifo.md
Name: uart_tx_holding_fifo

Overview:
Upstream feeder for the UART transmitter FSM, clocked on UCLK. Buffers bytes written by the bridge-side write logic, which is already synchronised to UCLK. Presents data_valid to the FSM only while the FSM is idle, and pops one byte per frame into a holding register. That register keeps tx_data and its parity bit stable for the whole frame, for the serializer and output mux.

Parameters:
DATA_WIDTH, 8, width of one transmitted character.
FIFO_DEPTH, 8, number of buffered characters; power of two, at least 2.

Ports:
UCLK  input  1  transmitter clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
wr_en  input  1  write strobe, one character per high cycle.
wr_data  input  DATA_WIDTH  character to enqueue.
parity_type  input  1  0 = even parity, 1 = odd parity; sampled at pop.
busy  input  1  transmitter FSM busy; low means the FSM is in IDLE.
data_valid  output  1  request to the FSM to start a frame.
tx_data  output  DATA_WIDTH  character of the current or most recent frame (holding register).
parity_bit  output  1  parity of tx_data per the parity_type captured at pop.
full  output  1  FIFO holds FIFO_DEPTH entries.
empty  output  1  FIFO holds 0 entries.
fill_level  output  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
overflow  output  1  sticky flag: a write was dropped.
overflow_clear  input  1  clears overflow.

Behaviour:
- Storage: circular buffer of FIFO_DEPTH x DATA_WIDTH.
  - Write and read pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - fill_level is a separate counter.
- full = (fill_level == FIFO_DEPTH); empty = (fill_level == 0). Both are combinational from fill_level.
- Write accepted: wr_en && !full. Stores wr_data at the write pointer; write pointer +1.
- Write dropped: wr_en && full. Storage and pointers are unchanged; overflow is set on that edge.
  - A write in the same cycle as a pop while full is still dropped. The full check uses the pre-edge state.
- data_valid = !empty && !busy (combinational). Never asserted while busy is high.
- Pop condition: data_valid high at a rising edge. On that edge:
  - the read pointer advances;
  - tx_data <= head entry;
  - parity_bit <= (XOR reduction of head entry) XOR parity_type.
- The FSM leaves IDLE on the same edge, so busy rises and data_valid drops. Exactly one pop occurs per frame.
- tx_data and parity_bit change only on a pop; they stay stable through the start, data, parity and stop bits.
- Write latency: a character written into an empty FIFO at edge N gives empty = 0 after N. data_valid can then be high in the following cycle, and the earliest pop is at edge N+1.
- fill_level update per edge: +1 on accepted write only; -1 on pop only; unchanged on accepted write plus pop together (possible only when 0 < fill_level < FIFO_DEPTH).
- Back-to-back frames: after the FSM returns to IDLE (busy low), a non-empty FIFO pops at the next edge. This gives exactly one idle cycle between frames.
- overflow clear: cleared on an edge with overflow_clear high. If a dropped write happens on the same edge, set wins.
- Reset (asynchronous, any time, including mid-frame):
  - pointers and fill_level = 0; empty = 1, full = 0;
  - data_valid = 0;
  - tx_data = 0, parity_bit = 0;
  - overflow = 0.
  - Buffered characters are discarded. Storage array contents are don't-care, with no reset required.
- No X on any output after reset.

Test Plan:
- Reset check: assert reset mid-stream with 3 entries -> empty = 1, fill_level = 0, data_valid = 0, tx_data = 0x00, parity_bit = 0, overflow = 0, all asynchronously.
- Single write, FSM idle: write 0xA5 (busy = 0), parity_type = 0 -> data_valid high in the next cycle. Pop on the following edge gives tx_data = 0xA5, parity_bit = 0, fill_level 1 -> 0.
- Odd parity: write 0x07, parity_type = 1, pop -> parity_bit = 0. Write 0x03, parity_type = 1, pop -> parity_bit = 1.
- Busy gating: queue 0x11, 0x22, 0x33 with busy = 1 for 20 cycles -> data_valid stays 0 and tx_data is unchanged. Then drop busy for one cycle per frame -> pops in order 0x11, 0x22, 0x33, one pop per busy-low window.
- Overflow and wrap: fill 8 entries (0x00..0x07) and write 0xFF while full -> 0xFF dropped, overflow = 1, fill_level = 8. Drain all entries -> order 0x00..0x07. Refill 8 more -> pointer wrap is correct. Pulse overflow_clear -> overflow = 0.
- Simultaneous write and pop at fill_level = 4 -> fill_level stays 4, the correct head is popped, and the new entry appears in order later.
